seq_mul_fx: RTL and testbench
=============================

Name: seq_mul_fx

Overview:
- Sequential unsigned fixed-point multiplier using shift-add, one partial product per clock.
- Counterpart to the team's restoring divider: same fixed-point format (SIZE-bit words, DEC_SIZE fractional bits).
- Used in the arithmetic datapath wherever a product of two fixed-point values is needed without a large combinational multiplier.
- Adds round-half-up, saturation and a restartable start/valid handshake.

Parameters:
- SIZE, 96, operand and result width in bits.
- DEC_SIZE, 32, number of fractional bits in a, b and out; legal range 0..SIZE-1.
- LOG2, 8, iteration counter width; must satisfy 2^LOG2 > SIZE.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- a  input  SIZE  multiplicand, unsigned fixed-point; sampled on the accepting edge only.
- b  input  SIZE  multiplier, unsigned fixed-point; sampled on the accepting edge only.
- out  output  SIZE  rounded, saturated product.
- valid  output  1  high while in DONE; out and overflow are stable.
- busy  output  1  high in RUN and FIN.
- overflow  output  1  result saturated; qualified by valid.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; out=0, valid=0, busy=0, overflow=0.
  - Internal product register and cnt cleared.
  - The in-flight operation is discarded.
- States: IDLE, RUN, FIN, DONE (2-bit encoding).
- IDLE:
  - start=1 at an edge: latch a into mcand; load P={SIZE'b0, b}; cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per edge:
  - sum = P[2*SIZE-1:SIZE] + (P[0] ? mcand : 0), computed (SIZE+1) bits wide.
  - P <= {sum, P[SIZE-1:1]}; this is a right shift that keeps the carry.
  - cnt <= cnt+1.
  - At the edge where cnt==SIZE-1, go to FIN. Exactly SIZE iterations, after which P = a*b.
- FIN, one cycle:
  - r = P[DEC_SIZE +: SIZE+1 extended to full upper range] + (DEC_SIZE>0 ? P[DEC_SIZE-1] : 0). This is round half up.
  - If any bit of the rounded value at or above SIZE is set (upper product bits P[2*SIZE-1:SIZE+DEC_SIZE] nonzero, or the rounding carries out), then out <= all ones and overflow <= 1.
  - Otherwise out <= r[SIZE-1:0] and overflow <= 0.
  - Go to DONE.
- DONE:
  - valid=1. out and overflow are held.
  - start=1 at an edge behaves exactly like IDLE acceptance: new operands are latched, go to RUN, valid drops on that edge.
  - Without start, stay in DONE indefinitely.
- Latency: accepting edge k → valid first high after edge k+SIZE+1. busy is high for SIZE+1 cycles.
- start while busy=1 is ignored; no queuing.
- Operand changes after the accepting edge have no effect.
- out holds its previous value during RUN/FIN; it is not qualified there.
- Zero operands need no special case: result 0, overflow=0.
- The counter never wraps, because LOG2 is sized to cover SIZE.

Test Plan:
- SIZE=16, DEC_SIZE=8: reset held mid-RUN, then released → out=0, valid=0, busy=0, overflow=0; state IDLE; no valid without a new start.
- SIZE=16, DEC_SIZE=8: a=0x0180 (1.5), b=0x0200 (2.0), start pulse → valid after exactly 17 cycles; out=0x0300, overflow=0; busy high for 17 cycles.
- SIZE=16, DEC_SIZE=8, rounding boundary:
  - a=0x0001, b=0x0080 → out=0x0001.
  - a=0x0001, b=0x007F → out=0x0000.
  - Both with overflow=0.
- SIZE=16, DEC_SIZE=8, saturation:
  - a=0x8000, b=0x0200 → out=0xFFFF, overflow=1.
  - a=0x7FC0, b=0x0201 (product 0xFFFFC0; the rounding carry overflows) → out=0xFFFF, overflow=1.
  - a=0xFFFF, b=0x0100 → out=0xFFFF, overflow=0.
- Handshake:
  - start pulsed again during RUN → ignored; the first result is unchanged.
  - In DONE, start with a=0x0300, b=0x0100 → valid drops next cycle; out=0x0300 after 17 more cycles.
  - Operands changed after the accepting edge do not affect the result.
- Default parameters (SIZE=96, DEC_SIZE=32): random unsigned operands, including all-ones and zero → out and overflow match a reference model (2*SIZE-bit product, round half up, saturate); latency 97 cycles.

Source files
------------

// File: rtl/seq_mul_fx.sv
// Sequential unsigned fixed-point multiplier (shift-add, one partial product per clock) with round-half-up and saturation.
// Result valid SIZE+1 cycles after the accepting edge; start is ignored while busy, and there is no queuing.
module seq_mul_fx #(
   parameter int SIZE     = 96,
   parameter int DEC_SIZE = 32,
   parameter int LOG2     = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic [SIZE-1:0] out,
   output logic            valid,
   output logic            busy,
   output logic            overflow
);

   typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

   localparam int RW = 2*SIZE - DEC_SIZE + 1;

   state_t            state, state_nxt;
   logic              accept;
   logic [SIZE-1:0]   mcand;
   logic [2*SIZE-1:0] prod;
   logic [LOG2-1:0]   cnt;
   logic [SIZE:0]     sum;
   logic              rnd_bit;
   logic [RW-1:0]     rnd_val;
   logic              sat;

   // The carry is kept in sum and shifted back into the top of prod.
   always_comb begin
      sum = {1'b0, prod[2*SIZE-1:SIZE]} + (prod[0] ? {1'b0, mcand} : {(SIZE+1){1'b0}});
   end

   generate
      if (DEC_SIZE > 0) begin : g_round
         assign rnd_bit = prod[DEC_SIZE-1];
      end else begin : g_no_round
         assign rnd_bit = 1'b0;
      end
   endgenerate

   always_comb begin
      rnd_val = {1'b0, prod[2*SIZE-1:DEC_SIZE]} + RW'(rnd_bit);
      sat     = |rnd_val[RW-1:SIZE];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      valid     = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LOG2'(SIZE-1)) state_nxt = FIN;
         end
         FIN: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            valid = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand    <= '0;
         prod     <= '0;
         cnt      <= '0;
         out      <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         mcand <= a;
         prod  <= {{SIZE{1'b0}}, b};
         cnt   <= '0;
      end else if (state == RUN) begin
         prod <= {sum, prod[SIZE-1:1]};
         cnt  <= cnt + 1'b1;
      end else if (state == FIN) begin
         out      <= sat ? {SIZE{1'b1}} : rnd_val[SIZE-1:0];
         overflow <= sat;
      end
   end

endmodule

// File: tb/tb_seq_mul_fx.sv
// Bench for seq_mul_fx: a 16-bit/8-fraction instance driven from a vector table and corner sequences,
// plus a default-parameter instance checked against a wide-product reference model.
module tb_seq_mul_fx;

   logic        clk = 1'b0;
   logic        reset;
   logic        start16, valid16, busy16, ovf16;
   logic [15:0] a16, b16, out16;
   logic        start96, valid96, busy96, ovf96;
   logic [95:0] a96, b96, out96;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [95:0] out;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] eo;
      logic        eovf;
      int          poke;
   } vec_t;

   exp_t q16[$];
   exp_t q96[$];
   vec_t tbl[8];

   always #5 clk = ~clk;

   seq_mul_fx #(.SIZE(16), .DEC_SIZE(8), .LOG2(5)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16),
      .out(out16), .valid(valid16), .busy(busy16), .overflow(ovf16)
   );

   seq_mul_fx dut96 (
      .clk(clk), .reset(reset), .start(start96), .a(a96), .b(b96),
      .out(out96), .valid(valid96), .busy(busy96), .overflow(ovf96)
   );

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t ref96(input logic [95:0] a, input logic [95:0] b);
      logic [191:0] p;
      logic [192:0] r;
      exp_t         e;
      p = {96'b0, a} * {96'b0, b};
      r = {1'b0, p >> 32} + 193'(p[31]);
      if (r[192:96] != '0) begin
         e.out = '1;
         e.ovf = 1'b1;
      end else begin
         e.out = r[95:0];
         e.ovf = 1'b0;
      end
      return e;
   endfunction

   // poke >= 0 re-asserts start with junk operands at that cycle of the run.
   task automatic run16(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eo, input logic eovf, input int poke);
      int   j;
      int   bc;
      exp_t e;
      @(negedge clk);
      a16 = a; b16 = b; start16 = 1'b1;
      q16.push_back('{out: {80'b0, eo}, ovf: eovf});
      @(posedge clk);
      j = 0; bc = 0;
      while (j < 300) begin
         @(negedge clk);
         start16 = (j == poke);
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         if (valid16) break;
         if (busy16) bc++;
         @(posedge clk);
         j++;
      end
      start16 = 1'b0;
      chk("lat16", 96'(j), 96'(17));
      chk("busy16", 96'(bc), 96'(17));
      e = q16.pop_front();
      chk("out16", 96'(out16), e.out);
      chk("ovf16", 96'(ovf16), 96'(e.ovf));
   endtask

   task automatic run96(input logic [95:0] a, input logic [95:0] b);
      int   j;
      int   bc;
      exp_t e;
      @(negedge clk);
      a96 = a; b96 = b; start96 = 1'b1;
      q96.push_back(ref96(a, b));
      @(posedge clk);
      j = 0; bc = 0;
      while (j < 400) begin
         @(negedge clk);
         start96 = 1'b0;
         a96 = ~a;
         b96 = {b[47:0], b[95:48]};
         if (valid96) break;
         if (busy96) bc++;
         @(posedge clk);
         j++;
      end
      chk("lat96", 96'(j), 96'(97));
      chk("busy96", 96'(bc), 96'(97));
      e = q96.pop_front();
      chk("out96", out96, e.out);
      chk("ovf96", 96'(ovf96), 96'(e.ovf));
   endtask

   function automatic logic [95:0] rnd96();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      int nv;
      int nb;
      reset = 1'b1; start16 = 1'b0; start96 = 1'b0;
      a16 = '0; b16 = '0; a96 = '0; b96 = '0;

      tbl[0] = '{a: 16'h0180, b: 16'h0200, eo: 16'h0300, eovf: 1'b0, poke: -1};
      tbl[1] = '{a: 16'h0001, b: 16'h0080, eo: 16'h0001, eovf: 1'b0, poke: -1};
      tbl[2] = '{a: 16'h0001, b: 16'h007F, eo: 16'h0000, eovf: 1'b0, poke: -1};
      tbl[3] = '{a: 16'h8000, b: 16'h0200, eo: 16'hFFFF, eovf: 1'b1, poke: 5};
      tbl[4] = '{a: 16'h7FC0, b: 16'h0201, eo: 16'hFFFF, eovf: 1'b1, poke: -1};
      tbl[5] = '{a: 16'hFFFF, b: 16'h0100, eo: 16'hFFFF, eovf: 1'b0, poke: 16};
      tbl[6] = '{a: 16'h0000, b: 16'h1234, eo: 16'h0000, eovf: 1'b0, poke: -1};
      tbl[7] = '{a: 16'h0300, b: 16'h0100, eo: 16'h0300, eovf: 1'b0, poke: 3};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out16", 96'(out16), 96'(0));
      chk("rst_valid16", 96'(valid16), 96'(0));
      chk("rst_busy16", 96'(busy16), 96'(0));
      chk("rst_ovf16", 96'(ovf16), 96'(0));
      chk("rst_valid96", 96'(valid96), 96'(0));
      reset = 1'b0;

      for (int i = 0; i < 8; i++)
         run16(tbl[i].a, tbl[i].b, tbl[i].eo, tbl[i].eovf, tbl[i].poke);

      // DONE holds its result without a new start.
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("hold_valid16", 96'(valid16), 96'(1));
      chk("hold_out16", 96'(out16), 96'(16'h0300));

      // Reset in the middle of a run discards the operation.
      a16 = 16'h0180; b16 = 16'h0200; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_out16", 96'(out16), 96'(0));
      chk("mid_rst_valid16", 96'(valid16), 96'(0));
      chk("mid_rst_busy16", 96'(busy16), 96'(0));
      chk("mid_rst_ovf16", 96'(ovf16), 96'(0));
      @(negedge clk);
      reset = 1'b0;
      nv = 0; nb = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (valid16) nv++;
         if (busy16) nb++;
      end
      chk("post_rst_valid16", 96'(nv), 96'(0));
      chk("post_rst_busy16", 96'(nb), 96'(0));

      run16(16'h0180, 16'h0200, 16'h0300, 1'b0, -1);

      run96('1, '1);
      run96('0, rnd96());
      run96('1, 96'h1_0000_0000);
      run96(rnd96(), 96'(32'h8000_0000));
      run96(96'h1, 96'h8000_0000);
      run96(96'h1, 96'h7FFF_FFFF);
      for (int k = 0; k < 4; k++) run96(rnd96(), rnd96());
      for (int k = 0; k < 3; k++) run96(rnd96(), 96'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
